// File: rtl/gcd_pkg.sv
// Shared types and default sizes for the subtractive-Euclid GCD engine.
package gcd_pkg;

  localparam int GCD_WIDTH_DEF  = 16;
  localparam int GCD_ITER_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_cmp_sub.sv
// Combinational magnitude compare plus larger-minus-smaller difference; zero latency.
module gcd_cmp_sub
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic [WIDTH-1:0] diff
);

  assign a_gt_b = (a > b);
  assign a_lt_b = (a < b);
  assign a_eq_b = (a == b);
  // The smaller is always taken from the larger, so the result never wraps.
  assign diff   = a_gt_b ? (a - b) : (b - a);

endmodule

// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD with start/done handshake; latency 1 (zero operand) or 2+subtractions; start ignored while busy.
// Optional macro GCD_ITER_COUNT_EN adds the iter_count output reporting subtractions of the last operation.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH  = GCD_WIDTH_DEF,
  parameter int ITER_W = GCD_ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  gcd_out,
  output logic              zero_err
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [ITER_W-1:0] iter_count
`endif
);

  if (WIDTH < 2 || WIDTH > 64 || ITER_W < 1) begin : g_bad_param
    $error("gcd_engine: WIDTH must be 2..64 and ITER_W at least 1");
  end

  gcd_state_t       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic [WIDTH-1:0] diff;
  logic             a_zero;
  logic             b_zero;

`ifdef GCD_ITER_COUNT_EN
  logic [ITER_W-1:0] iter;
`endif

  gcd_cmp_sub #(
    .WIDTH (WIDTH)
  ) u_cmp_sub (
    .a      (a_reg),
    .b      (b_reg),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .a_eq_b (a_eq_b),
    .diff   (diff)
  );

  assign a_zero = (a_in == '0);
  assign b_zero = (b_in == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      gcd_out    <= '0;
      zero_err   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
      iter       <= '0;
      iter_count <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (a_zero || b_zero) begin
              // gcd(x,0)=x; both zero has no defined result and is flagged.
              state    <= DONE;
              gcd_out  <= a_in | b_in;
              zero_err <= a_zero && b_zero;
`ifdef GCD_ITER_COUNT_EN
              iter_count <= '0;
`endif
            end else begin
              state    <= RUN;
              a_reg    <= a_in;
              b_reg    <= b_in;
              zero_err <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
              iter     <= '0;
`endif
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (a_eq_b) begin
            state   <= DONE;
            gcd_out <= a_reg;
`ifdef GCD_ITER_COUNT_EN
            iter_count <= iter;
`endif
          end else begin
            if (a_gt_b) begin
              a_reg <= diff;
            end else if (a_lt_b) begin
              b_reg <= diff;
            end
`ifdef GCD_ITER_COUNT_EN
            if (iter != '1) begin
              iter <= iter + 1'b1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed scenarios plus random operands against a modulo-Euclid reference.
module tb_gcd_engine;

  localparam int LIMIT = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [15:0] gcd16;
  logic        zerr16;
  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [7:0]  gcd8;
  logic        zerr8;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iter16;
  logic [15:0] iter8;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(16), .ITER_W(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start16),
    .a_in     (a16),
    .b_in     (b16),
    .busy     (busy16),
    .done     (done16),
    .gcd_out  (gcd16),
    .zero_err (zerr16)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_count (iter16)
`endif
  );

  gcd_engine #(.WIDTH(8), .ITER_W(16)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .a_in     (a8),
    .b_in     (b8),
    .busy     (busy8),
    .done     (done8),
    .gcd_out  (gcd8),
    .zero_err (zerr8)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_count (iter8)
`endif
  );

  // Reference: division-based Euclid; subtractions = sum of quotients minus the final one reaching zero.
  function automatic longint ref_gcd(input longint x, input longint y);
    longint t;
    if (x == 0) return y;
    if (y == 0) return x;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic longint ref_subs(input longint x, input longint y);
    longint s;
    longint t;
    if (x == 0 || y == 0) return 0;
    s = 0;
    while (y != 0) begin
      s = s + x / y;
      t = x % y;
      x = y;
      y = t;
    end
    return s - 1;
  endfunction

  function automatic int ref_lat(input longint x, input longint y);
    if (x == 0 || y == 0) return 1;
    return 2 + int'(ref_subs(x, y));
  endfunction

  // Launch one operation and count edges from the accepting edge until done is seen.
  task automatic op16(input logic [15:0] x, input logic [15:0] y, output int lat, output bit tmo);
    start16 = 1'b1; a16 = x; b16 = y;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 1;
    while (done16 !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    tmo = (done16 !== 1'b1);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, output int lat, output bit tmo);
    start8 = 1'b1; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    while (done8 !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    tmo = (done8 !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start16 = 1'b0; start8 = 1'b0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0;
    #1;
    total++; if (busy16 !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy16); end
    total++; if (done16 !== 1'b0) begin bad++; $display("FAIL reset_done got %0b want 0", done16); end
    total++; if (gcd16 !== 16'd0) begin bad++; $display("FAIL reset_gcd got %0d want 0", gcd16); end
    total++; if (zerr16 !== 1'b0) begin bad++; $display("FAIL reset_zero_err got %0b want 0", zerr16); end
`ifdef GCD_ITER_COUNT_EN
    total++; if (iter16 !== 16'd0) begin bad++; $display("FAIL reset_iter got %0d want 0", iter16); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; bit tmo;
    op16(16'd48, 16'd18, lat, tmo);
    total++; if (tmo || lat != 6) begin bad++; $display("FAIL basic_48_18_latency got %0d want 6", lat); end
    total++; if (gcd16 !== 16'd6) begin bad++; $display("FAIL basic_48_18_gcd got %0d want 6", gcd16); end
`ifdef GCD_ITER_COUNT_EN
    total++; if (iter16 !== 16'd4) begin bad++; $display("FAIL basic_48_18_iter got %0d want 4", iter16); end
`endif
    op16(16'd12, 16'd12, lat, tmo);
    total++; if (tmo || lat != 2) begin bad++; $display("FAIL equal_latency got %0d want 2", lat); end
    total++; if (gcd16 !== 16'd12) begin bad++; $display("FAIL equal_gcd got %0d want 12", gcd16); end
`ifdef GCD_ITER_COUNT_EN
    total++; if (iter16 !== 16'd0) begin bad++; $display("FAIL equal_iter got %0d want 0", iter16); end
`endif
    op16(16'd0, 16'd7, lat, tmo);
    total++; if (tmo || lat != 1) begin bad++; $display("FAIL one_zero_latency got %0d want 1", lat); end
    total++; if (gcd16 !== 16'd7 || zerr16 !== 1'b0) begin bad++; $display("FAIL one_zero_result got gcd=%0d zerr=%0b want gcd=7 zerr=0", gcd16, zerr16); end
    @(posedge clk); #1;
    total++; if (done16 !== 1'b0) begin bad++; $display("FAIL done_one_cycle got %0b want 0", done16); end
  endtask

  task automatic test_zero_err();
    int lat; bit tmo;
    op16(16'd0, 16'd0, lat, tmo);
    total++; if (tmo || lat != 1) begin bad++; $display("FAIL both_zero_latency got %0d want 1", lat); end
    total++; if (gcd16 !== 16'd0 || zerr16 !== 1'b1) begin bad++; $display("FAIL both_zero_result got gcd=%0d zerr=%0b want gcd=0 zerr=1", gcd16, zerr16); end
    op16(16'd35, 16'd21, lat, tmo);
    total++; if (tmo || gcd16 !== 16'd7 || zerr16 !== 1'b0) begin bad++; $display("FAIL zero_err_clear got gcd=%0d zerr=%0b want gcd=7 zerr=0", gcd16, zerr16); end
  endtask

  task automatic test_ignore_busy();
    int lat;
    start16 = 1'b1; a16 = 16'd1000; b16 = 16'd1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 1;
    repeat (5) begin @(posedge clk); #1; lat++; end
    start16 = 1'b1; a16 = 16'd9; b16 = 16'd3;
    @(posedge clk); #1;
    start16 = 1'b0; lat++;
    total++; if (busy16 !== 1'b1) begin bad++; $display("FAIL ignore_still_busy got %0b want 1", busy16); end
    while (done16 !== 1'b1 && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 1001) begin bad++; $display("FAIL ignore_latency got %0d want 1001", lat); end
    total++; if (gcd16 !== 16'd1) begin bad++; $display("FAIL ignore_gcd got %0d want 1", gcd16); end
`ifdef GCD_ITER_COUNT_EN
    total++; if (iter16 !== 16'd999) begin bad++; $display("FAIL ignore_iter got %0d want 999", iter16); end
`endif
  endtask

  task automatic test_reset_mid_run();
    int lat; bit tmo; int seen;
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'd2;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (busy16 !== 1'b0 || done16 !== 1'b0 || gcd16 !== 16'd0 || zerr16 !== 1'b0) begin
      bad++; $display("FAIL abort_outputs got busy=%0b done=%0b gcd=%0d zerr=%0b want all 0", busy16, done16, gcd16, zerr16);
    end
    #4 rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (done16 === 1'b1 || busy16 === 1'b1) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
    op16(16'd9, 16'd6, lat, tmo);
    total++; if (tmo || lat != 4 || gcd16 !== 16'd3) begin bad++; $display("FAIL after_abort got gcd=%0d lat=%0d want gcd=3 lat=4", gcd16, lat); end
  endtask

  task automatic test_back_to_back();
    int lat; bit tmo;
    op8(8'd255, 8'd85, lat, tmo);
    total++; if (tmo || lat != 4 || gcd8 !== 8'd85) begin bad++; $display("FAIL w8_255_85 got gcd=%0d lat=%0d want gcd=85 lat=4", gcd8, lat); end
`ifdef GCD_ITER_COUNT_EN
    total++; if (iter8 !== 16'd2) begin bad++; $display("FAIL w8_255_85_iter got %0d want 2", iter8); end
`endif
    start8 = 1'b1; a8 = 8'd14; b8 = 8'd21;
    total++; if (done8 !== 1'b1) begin bad++; $display("FAIL b2b_old_done got %0b want 1", done8); end
    @(posedge clk); #1;
    start8 = 1'b0;
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL b2b_accepted got busy=%0b want 1", busy8); end
    lat = 1;
    while (done8 !== 1'b1 && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    total++; if (lat != 4 || gcd8 !== 8'd7) begin bad++; $display("FAIL b2b_result got gcd=%0d lat=%0d want gcd=7 lat=4", gcd8, lat); end
  endtask

  task automatic test_random();
    int lat; bit tmo;
    logic [15:0] x;
    logic [15:0] y;
    longint eg;
    for (int i = 0; i < 24; i++) begin
      x = 16'($urandom_range(1, 600));
      y = 16'($urandom_range(1, 600));
      if ($urandom_range(0, 7) == 0) x = '0;
      if ($urandom_range(0, 7) == 0) y = '0;
      eg = ref_gcd(longint'(x), longint'(y));
      op16(x, y, lat, tmo);
      total++; if (tmo || lat != ref_lat(longint'(x), longint'(y))) begin
        bad++; $display("FAIL rand_latency a=%0d b=%0d got %0d want %0d", x, y, lat, ref_lat(longint'(x), longint'(y)));
      end
      total++; if (longint'(gcd16) != eg || zerr16 !== (x == 0 && y == 0)) begin
        bad++; $display("FAIL rand_result a=%0d b=%0d got gcd=%0d zerr=%0b want gcd=%0d", x, y, gcd16, zerr16, eg);
      end
`ifdef GCD_ITER_COUNT_EN
      total++; if (longint'(iter16) != ref_subs(longint'(x), longint'(y))) begin
        bad++; $display("FAIL rand_iter a=%0d b=%0d got %0d want %0d", x, y, iter16, ref_subs(longint'(x), longint'(y)));
      end
`endif
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_err();
    test_ignore_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised subtractive-Euclid GCD unit with its own controller and a start/done handshake. It replaces the split datapath/controller pair.
- Two WIDTH-bit unsigned operands are captured on start. The larger is reduced by the smaller once per cycle until the two are equal, and the result is held with a one-cycle done pulse.
- It sits beside other arithmetic engines on a shared bus-side wrapper that drives start and samples done.

Parameters:
- WIDTH, 16, operand and result width in bits (legal 2..64).
- ITER_W, 16, width of the internal iteration counter; the counter saturates at all-ones.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a_in  input  WIDTH  operand A; sampled with start.
- b_in  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when gcd_out becomes valid.
- gcd_out  output  WIDTH  result; held until the next accepted start.
- zero_err  output  1  set with done when both operands are 0; cleared on the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE
  - busy=0, done=0, zero_err=0
  - gcd_out=0
  - a_reg=0, b_reg=0
  - iter count=0
- Release of reset is synchronous to clk; the first start can be accepted on the first edge after release.
- Reset asserted mid-RUN aborts the operation immediately. No done is produced.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - If a_in=0 and b_in=0: go to DONE; gcd_out=0; zero_err=1.
  - Else if a_in=0 or b_in=0: go to DONE; gcd_out=a_in|b_in (gcd(x,0)=x); zero_err=0.
  - Else: a_reg=a_in, b_reg=b_in, iter=0, zero_err=0; go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - a_reg==b_reg: gcd_out<=a_reg; go to DONE.
  - a_reg>b_reg: a_reg<=a_reg-b_reg; iter++.
  - a_reg<b_reg: b_reg<=b_reg-a_reg; iter++.
- Compare is an unsigned WIDTH-bit compare. Subtraction is WIDTH bits; it cannot underflow because the larger operand is always reduced by the smaller.
- Outputs are decoded from state:
  - busy=1 exactly in RUN.
  - done=1 exactly in DONE, so it lasts one cycle unless DONE is immediately re-entered via a zero-operand start.
- start while busy=1 is ignored; it is not queued, and operands are not re-sampled.
- Latency, counted from the edge that accepts start to the edge that enters DONE:
  - Zero operand: 1 cycle.
  - Otherwise: 1 + (number of subtractions) + 1 cycles.
  - Example: a_in=b_in gives 2 cycles.
- Back-to-back: start asserted while in DONE is accepted on that edge. done for the old result is still visible during that cycle.
- Worst case: operands (2^WIDTH-1, 1) need 2^WIDTH-2 subtractions. This is accepted; the wrapper owns any timeout.

Optional Feature:
- Macro GCD_ITER_COUNT_EN.
- When defined:
  - Adds output port iter_count [ITER_W-1:0], equal to the number of subtractions of the last completed operation.
  - Valid from done and held until the next done.
  - Reset value 0. Zero-operand operations report 0.
  - Saturates at 2^ITER_W-1.
- When undefined: the port and the counter register are absent, and there is no other behavioural difference.

Decomposition:
- Package gcd_pkg holds:
  - the state enum gcd_state_t {IDLE, RUN, DONE}
  - the default width constant GCD_WIDTH_DEF=16
  - the default ITER_W constant
- One combinational sub-module, gcd_cmp_sub #(WIDTH):
  - inputs a, b
  - outputs a_gt_b, a_lt_b, a_eq_b, and diff = larger minus smaller
- The FSM and registers stay in gcd_engine.

Test Plan:
- Reset, then start with a_in=48, b_in=18 -> busy for 5 cycles, done on the 6th cycle after the start edge, gcd_out=6, iter_count=4 (if enabled).
- start a_in=12, b_in=12 -> done 2 cycles after the start edge, gcd_out=12, iter_count=0; then a_in=0, b_in=7 -> done 1 cycle after start, gcd_out=7, zero_err=0.
- start a_in=0, b_in=0 -> done after 1 cycle, gcd_out=0, zero_err=1; next start (35,21) clears zero_err and gives gcd_out=7.
- start (1000,1) with WIDTH=16, then pulse start with (9,3) mid-RUN -> second start is ignored; gcd_out=1; iter_count=999.
- start (65535,2), drop rst_n for half a cycle mid-RUN -> outputs go to 0 immediately, no done pulse; after release, start (9,6) -> gcd_out=3.
- WIDTH=8 instance: start (255,85) -> gcd_out=85, iter_count=2; start in the DONE cycle with (14,21) -> accepted, gcd_out=7.
